// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Latency: none; this file holds wires only.
// Backpressure: none. The master drives start/a/b/bin. The slave answers with busy/done/d/bout.
// Ports: start (request), a/b (operands), bin (borrow-in),
//        busy (shifting), done (one-cycle result strobe), d/bout (registered result).
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - bin, one full-subtractor bit per clock, LSB first.
// Latency: start accepted at edge 0, done high in the cycle after edge WIDTH, next start at edge WIDTH+2.
// Backpressure: start is honoured only while idle; requests during busy/done are dropped, not queued.
// Ports: clk, rst (synchronous, active-high), bus (slave side of serial_subtractor_if).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // acc_a starts as the minuend. Each difference bit enters at the MSB as the
    // consumed minuend bit leaves at the LSB. After WIDTH shifts, the register
    // holds the complete difference, so no separate result shifter is needed.
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] reg_b;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;

    logic             a0;
    logic             b0;
    logic             diff_bit;
    logic             brw_next;
    logic             last_bit;
    logic [WIDTH-1:0] acc_a_next;
    logic             busy_c;
    logic             done_c;

    // Full-subtractor cell
    assign a0       = acc_a[0];
    assign b0       = reg_b[0];
    assign diff_bit = a0 ^ b0 ^ brw_q;
    assign brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
    assign last_bit = (cnt_q == CNT_LAST);

    // Written as shift-or so the expression stays legal when WIDTH is 1.
    assign acc_a_next = (acc_a >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_c = 1'b1;
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_a  <= '0;
            reg_b  <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_a <= bus.a;
                        reg_b <= bus.b;
                        brw_q <= bus.bin;
                        cnt_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    acc_a <= acc_a_next;
                    reg_b <= reg_b >> 1;
                    brw_q <= brw_next;
                    cnt_q <= cnt_q + CNT_ONE;
                    // The outputs update only on the final bit. They keep the
                    // previous result for the whole operation.
                    if (last_bit) begin
                        d_q    <= acc_a_next;
                        bout_q <= brw_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8 and WIDTH 1.
// Stimulus pushes expected results into per-instance queues, and per-instance monitors compare them on done.
// The reference computes a - b - bin with integer arithmetic.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic [7:0] d;
        logic       bout;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit         en   [2];
    int         run  [2];
    logic [7:0] hold [2];
    logic       hbout[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int w, int a, int b, int bin, int accept_cyc);
        exp_t e;
        int   m;
        int   diff;
        m      = 1 << w;
        diff   = a - b - bin;
        e.d    = 8'(((diff % m) + m) % m);
        e.bout = (a < b + bin);
        e.cyc  = accept_cyc + w;
        return e;
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    function automatic int qsize(int i);
        return (i == 0) ? q8.size() : q1.size();
    endfunction

    task automatic mon_step(int i, int w, logic r, logic busy, logic done,
                            logic [7:0] d, logic bout);
        exp_t e;
        if (r) begin
            en[i]    = 1'b1;
            run[i]   = 0;
            hold[i]  = 8'h00;
            hbout[i] = 1'b0;
            chk("rst_busy", i, 32'(busy), 0);
            chk("rst_done", i, 32'(done), 0);
            chk("rst_d",    i, 32'(d),    0);
            chk("rst_bout", i, 32'(bout), 0);
            return;
        end
        if (!en[i]) return;
        chk("busy_done_excl", i, 32'(busy & done), 0);
        if (busy) begin
            run[i]++;
        end else if (run[i] > 0) begin
            chk("busy_len", i, 32'(run[i]), 32'(w));
            chk("done_after_busy", i, 32'(done), 1);
            run[i] = 0;
        end
        if (done === 1'b1) begin
            if (qsize(i) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done inst%0d cyc %0d got d=%0h bout=%0b expected no done",
                         i, cyc, d, bout);
            end else begin
                e = (i == 0) ? q8.pop_front() : q1.pop_front();
                chk("d",         i, 32'(d),    32'(e.d));
                chk("bout",      i, 32'(bout), 32'(e.bout));
                chk("done_cycle", i, 32'(cyc), 32'(e.cyc));
                hold[i]  = e.d;
                hbout[i] = e.bout;
            end
        end else begin
            chk("d_hold",    i, 32'(d),    32'(hold[i]));
            chk("bout_hold", i, 32'(bout), 32'(hbout[i]));
        end
    endtask

    logic r8, r1;
    always @(posedge clk) begin
        r8 = rst;
        #1;
        mon_step(0, 8, r8, if8.busy, if8.done, if8.d, if8.bout);
    end
    always @(posedge clk) begin
        r1 = rst;
        #1;
        mon_step(1, 1, r1, if1.busy, if1.done, {7'b0, if1.d}, if1.bout);
    end

    task automatic set_in(int i, bit s, int a, int b, int bin);
        if (i == 0) begin
            if8.start = s;
            if8.a     = 8'(a);
            if8.b     = 8'(b);
            if8.bin   = 1'(bin);
        end else begin
            if1.start = s;
            if1.a     = 1'(a);
            if1.b     = 1'(b);
            if1.bin   = 1'(bin);
        end
    endtask

    // Expects the instance to be idle in the coming cycle. Returns at the negedge after the accept edge.
    task automatic issue(int i, int a, int b, int bin, bit expect_it);
        exp_t e;
        int   w;
        w = (i == 0) ? 8 : 1;
        @(negedge clk);
        set_in(i, 1'b1, a, b, bin);
        @(posedge clk);
        #1;
        e = model(w, a, b, bin, cyc);
        if (expect_it) begin
            if (i == 0) q8.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        set_in(i, 1'b0, $urandom, $urandom, $urandom);
    endtask

    // Waits for all queued results while scrambling the operand inputs. Returns with the instance idle.
    task automatic drain(int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            set_in(i, 1'b0, $urandom, $urandom, $urandom);
            if (qsize(i) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout inst%0d got %0d pending expected 0", i, qsize(i));
            if (i == 0) q8.delete();
            else        q1.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        exp_t e;
        rst = 1'b1;
        // A start during reset must be overridden.
        set_in(0, 1'b1, 8'h12, 8'h34, 0);
        set_in(1, 1'b1, 1, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 1'b0, 0, 0, 0);
        set_in(1, 1'b0, 0, 0, 0);
        @(posedge clk);

        // Directed WIDTH=8 cases.
        issue(0, 8'h5A, 8'h23, 0, 1); drain(0);
        issue(0, 8'h10, 8'h20, 0, 1); drain(0);
        issue(0, 8'h00, 8'h00, 1, 1); drain(0);
        issue(0, 8'hFF, 8'hFF, 0, 1); drain(0);
        issue(0, 8'hFF, 8'h00, 1, 1); drain(0);

        // A start in SHIFT cycle 3 is ignored.
        issue(0, 8'h80, 8'h01, 0, 1);
        @(negedge clk);
        @(negedge clk);
        set_in(0, 1'b1, 8'h00, 8'h01, 0);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00, 8'h01, 0);
        drain(0);
        repeat (12) @(negedge clk);

        // Reset in SHIFT cycle 4 aborts the operation without a done pulse.
        issue(0, 8'hAA, 8'h55, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(0, 8'h09, 8'h04, 0, 1); drain(0);

        // Random operands with inputs scrambled during SHIFT.
        for (int n = 0; n < 25; n++) begin
            issue(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), 1);
            drain(0);
        end

        // Start held high: one accept every WIDTH+2 edges.
        @(negedge clk);
        set_in(0, 1'b1, 8'h03, 8'h01, 0);
        @(posedge clk);
        #1;
        e0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e = model(8, 3, 1, 0, e0 + k * 10);
            q8.push_back(e);
        end
        while (cyc < e0 + 20) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        set_in(0, 1'b0, 8'h03, 8'h01, 0);
        drain(0);

        // WIDTH=1: all eight {a,b,bin} combinations.
        for (int c = 0; c < 8; c++) begin
            issue(1, (c >> 2) & 1, (c >> 1) & 1, c & 1, 1);
            drain(1);
        end

        repeat (4) @(negedge clk);
        chk("q8_empty", 0, 32'(q8.size()), 0);
        chk("q1_empty", 1, 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
